// File: rtl/lu_recompose.sv
// Rebuilds A = L*U from a packed Doolittle LU matrix using one sequential
// signed fixed-point multiply-accumulate (one product term per clock).
module lu_recompose #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N*N*DATA_W-1:0]      lu,
    output logic                       busy,
    output logic                       done,
    output logic [N*N*DATA_W-1:0]      ans
);

    localparam int NN    = N * N;
    localparam int ACC_W = 2 * DATA_W + 2;
    localparam int IW    = (N > 1) ? $clog2(N) : 1;
    localparam int EW    = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [IW-1:0]     LAST_IDX = IW'(N - 1);
    localparam logic [DATA_W-1:0] ONE      = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;
    localparam logic [DATA_W-1:0] SAT_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]               state_reg;
    logic [IW-1:0]            i_reg, j_reg, k_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     busy_reg, done_reg;
    logic [DATA_W-1:0]        lu_reg  [NN];
    logic [DATA_W-1:0]        ans_reg [NN];
    logic [DATA_W-1:0]        lu_word [NN];

    // Element (i,j) lives at word index i*N+j counted from the MSB end.
    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_pack
            assign lu_word[gi] = lu[(NN-gi)*DATA_W-1 -: DATA_W];
            assign ans[(NN-gi)*DATA_W-1 -: DATA_W] = ans_reg[gi];
        end
    endgenerate

    assign busy = busy_reg;
    assign done = done_reg;

    logic [IW-1:0]              k_max;
    logic                       last_k, last_elem;
    logic [EW-1:0]              l_idx, u_idx, e_idx;
    logic [DATA_W-1:0]          l_op, u_op;
    logic signed [2*DATA_W-1:0] l_ext, u_ext, prod;
    logic signed [ACC_W-1:0]    acc_sum, shifted;
    logic [ACC_W-DATA_W:0]      hi_bits;
    logic [DATA_W-1:0]          sat_val;

    always_comb begin
        k_max     = (i_reg < j_reg) ? i_reg : j_reg;
        last_k    = (k_reg == k_max);
        last_elem = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);
        l_idx     = EW'(int'(i_reg) * N + int'(k_reg));
        u_idx     = EW'(int'(k_reg) * N + int'(j_reg));
        e_idx     = EW'(int'(i_reg) * N + int'(j_reg));
        // The unit diagonal of L is implicit; that slot holds U(i,i).
        l_op      = (k_reg == i_reg) ? ONE : lu_reg[l_idx];
        u_op      = lu_reg[u_idx];
        l_ext     = {{DATA_W{l_op[DATA_W-1]}}, l_op};
        u_ext     = {{DATA_W{u_op[DATA_W-1]}}, u_op};
        prod      = l_ext * u_ext;
        acc_sum   = acc_reg + {{2{prod[2*DATA_W-1]}}, prod};
        shifted   = acc_sum >>> FRAC_W;
        hi_bits   = shifted[ACC_W-1:DATA_W-1];
        // In range only when every bit above the result sign matches it.
        if ((&hi_bits) || (~|hi_bits)) begin
            sat_val = shifted[DATA_W-1:0];
        end else if (shifted[ACC_W-1]) begin
            sat_val = SAT_MIN;
        end else begin
            sat_val = SAT_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
            i_reg     <= '0;
            j_reg     <= '0;
            k_reg     <= '0;
            acc_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            for (int e = 0; e < NN; e++) begin
                lu_reg[e]  <= '0;
                ans_reg[e] <= '0;
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        for (int e = 0; e < NN; e++) begin
                            lu_reg[e] <= lu_word[e];
                        end
                        busy_reg  <= 1'b1;
                        i_reg     <= '0;
                        j_reg     <= '0;
                        k_reg     <= '0;
                        acc_reg   <= '0;
                        state_reg <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (last_k) begin
                        ans_reg[e_idx] <= sat_val;
                        acc_reg        <= '0;
                        k_reg          <= '0;
                        if (j_reg == LAST_IDX) begin
                            j_reg <= '0;
                            i_reg <= i_reg + 1'b1;
                        end else begin
                            j_reg <= j_reg + 1'b1;
                        end
                        if (last_elem) begin
                            state_reg <= S_FIN;
                        end
                    end else begin
                        acc_reg <= acc_sum;
                        k_reg   <= k_reg + 1'b1;
                    end
                end
                S_FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lu_recompose.md
Name: lu_recompose

Overview:
- Inverse of the LU decomposition stage: takes a packed Doolittle LU result and rebuilds A = L*U.
- Packed form: unit-diagonal L stored strictly below the diagonal; U stored on and above the diagonal.
- Sits after the decomposition block, for self-check and round-trip verification, and shares its packed matrix bus format.
- Uses one sequential signed fixed-point multiply-accumulate, one product term per clock.

Parameters:
N, 4, matrix dimension (N x N)
DATA_W, 32, element width, signed two's complement
FRAC_W, 16, fractional bits (default Q16.16)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  reset, asynchronous, active-low
start  input  1  single-cycle request; sampled only when idle
lu  input  N*N*DATA_W  packed LU matrix; element (i,j) at bits [(N*N-i*N-j)*DATA_W-1 -: DATA_W], so (0,0) is the MSB word
busy  output  1  high from the accepting edge until done
done  output  1  one-cycle pulse when ans is complete
ans  output  N*N*DATA_W  recomposed matrix A, same packing as lu

Behaviour:
- Reset (rst=0, asynchronous): ans=0, busy=0, done=0, FSM in IDLE, accumulator and indices cleared.
- FSM states: IDLE, MAC, FIN.
  - IDLE: start=1 at an edge captures lu into an internal register, sets busy=1, sets i=j=k=0, clears the accumulator, and moves to MAC.
  - MAC: one term per edge, acc += L(i,k)*U(k,j) for k = 0..min(i,j).
  - At the last k of element (i,j): write sat(acc>>>FRAC_W) into ans(i,j) on the same edge, clear acc, and advance j, then i (row-major).
  - After element (N-1,N-1) is written: move to FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then return to IDLE.
- Operand rules:
  - L(i,k) = lu(i,k) for k<i.
  - L(i,i) = 1<<FRAC_W (implicit unit diagonal).
  - U(k,j) = lu(k,j) for k<=j.
  - Upper entries of L and lower entries of U are never read.
- Arithmetic:
  - Full 2*DATA_W signed product.
  - Accumulator is 2*DATA_W+2 bits; no intermediate truncation.
  - Final result is an arithmetic right shift by FRAC_W (rounds toward -inf), then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Latency:
  - T = sum over i,j of (min(i,j)+1); T = 30 for N=4.
  - With start accepted at edge E, done is high after edge E+T+1 (E+31 for N=4).
- Output hold: each ans element updates only when that element is written. After done, ans holds until the next accepted start. During a run, elements not yet written keep their previous-run values.
- Boundary cases:
  - start while busy or in FIN: ignored, no restart, no queuing.
  - start held high: a new run starts on the first edge back in IDLE.
  - lu changes after acceptance: no effect, because the captured copy is used.
  - Reset mid-run: run aborted, all outputs return to reset values immediately, and no done is issued.
  - Overflow of a single element saturates that element only; other elements are unaffected.

Test Plan:
- Identity: lu = 1.0 (0x00010000) on the diagonal, 0 elsewhere; pulse start -> done exactly 31 clocks after the start edge; ans = identity; busy high for 31 cycles.
- Single multiplier: identity plus lu(1,0)=2.0 (0x00020000) -> ans row1 = {0x00020000, 0x00010000, 0, 0}; all other rows are identity.
- Fractional/negative 2x2 block: lu(0,0)=2.0, lu(0,1)=3.0, lu(1,0)=1.5 (0x00018000), lu(1,1)=-0.5 (0xFFFF8000), lu(2,2)=lu(3,3)=1.0 -> ans(0,0)=0x00020000, ans(0,1)=0x00030000, ans(1,0)=0x00030000, ans(1,1)=0x00040000.
- Saturation: identity with lu(0,0)=0x7FFF0000 and lu(1,0)=2.0 -> ans(1,0)=0x7FFFFFFF, ans(0,0)=0x7FFF0000; with lu(0,0)=0x80000000 -> ans(1,0)=0x80000000.
- Start while busy: second start pulse 10 cycles into a run, with a different lu -> exactly one done at cycle 31; ans matches the first lu.
- Reset mid-run: rst=0 at cycle 12 -> ans=0, busy=0, done=0 asynchronously; after rst=1 and a new start, the correct result arrives at cycle 31.
